// File: rtl/sp_mem_arb_pkg.sv
// Shared types and the round-robin search helper for the single-port memory arbiter.
package sp_mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  // First set bit of req searching upward from last+1, wrapping modulo n.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        n);
    logic [2:0]  pick;
    logic        hit;
    int unsigned idx;
    pick = last;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(last) + k) % n;
      if (!hit && (k <= n) && req[idx[2:0]]) begin
        pick = idx[2:0];
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sp_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: next requester after last_i that has its request bit set.
module rr_pick
  import sp_mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      idx_o,
  output logic               found_o
);

  assign idx_o   = IW'(rr_next(8'(req_i), 3'(last_i), NUM_REQ));
  assign found_o = |req_i;

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin, burst-locked arbiter sharing one single-port memory between NUM_REQ requesters,
// with registered commands and a latency-matched shift register routing read data back.
module sp_mem_arbiter
  import sp_mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned RD_LATENCY = 1,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned IW         = $clog2(NUM_REQ),
  localparam int unsigned SW         = DATA_WIDTH / 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*SW-1:0]         req_wstrb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic [SW-1:0]                 mem_write_strb,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  arb_state_t            state_q;
  logic [IW-1:0]         grant_id_q;
  logic [IW-1:0]         last_grant_q;
  logic [7:0]            beat_cnt_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [SW-1:0]         mem_wstrb_q;

  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [IW-1:0]         rd_id_q [RD_LATENCY];
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  accept;
  logic                  g_write;
  logic                  g_last;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [SW-1:0]         g_wstrb;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign req_ready = (state_q == ARB_GRANT) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign accept    = (state_q == ARB_GRANT) && req_valid[grant_id_q];
  assign g_write   = req_write[grant_id_q];
  assign g_last    = req_last[grant_id_q];
  assign g_addr    = req_addr[grant_id_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_wdata   = req_wdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_wstrb   = req_wstrb[grant_id_q*SW +: SW];

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      // Strobes and write payload are single-cycle; only an accepted beat raises them.
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id_q   <= pick_idx;
            last_grant_q <= pick_idx;
            beat_cnt_q   <= '0;
            state_q      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            mem_read_q  <= ~g_write;
            mem_write_q <= g_write;
            mem_addr_q  <= g_addr;
            if (g_write) begin
              mem_wdata_q <= g_wdata;
              mem_wstrb_q <= g_wstrb;
            end
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (g_last || (beat_cnt_q == 8'(MAX_BURST - 1))) begin
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // grant_id_q still names the issuer while mem_read_q is high, even if the grant was just released.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_vld_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_id_q[i] <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rd_vld_q[0] <= mem_read_q;
      rd_id_q[0]  <= grant_id_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
      rsp_valid_q <= '0;
      if (rd_vld_q[RD_LATENCY-1]) begin
        rsp_valid_q[rd_id_q[RD_LATENCY-1]] <= 1'b1;
        rsp_rdata_q                        <= mem_read_data;
      end
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write_strb = mem_wstrb_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sp_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int LA = 1;
  localparam int MB = 4;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_write, req_last, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, mem_read_data, mem_write_data;
  logic            mem_read, mem_write, busy;
  logic [AW-1:0]   mem_address;
  logic [SW-1:0]   mem_write_strb;
  logic [0:0]      grant_id;

  logic [N-1:0]    b_valid, b_ready, b_write, b_last, b_rsp_valid;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata;
  logic [N*SW-1:0] b_wstrb;
  logic [DW-1:0]   b_rsp_rdata, b_mrdata, b_mwdata, b_p1, b_p2;
  logic            b_mread, b_mwrite, b_busy;
  logic [AW-1:0]   b_maddr;
  logic [SW-1:0]   b_mstrb;
  logic [0:0]      b_gid;

  logic [31:0] rom [64];

  sp_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LA), .MAX_BURST(MB)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_strb(mem_write_strb), .mem_read_data(mem_read_data),
    .grant_id(grant_id), .busy(busy)
  );

  sp_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LB), .MAX_BURST(16)) dut_lat3 (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write), .req_last(b_last),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_read(b_mread), .mem_write(b_mwrite), .mem_address(b_maddr),
    .mem_write_data(b_mwdata), .mem_write_strb(b_mstrb), .mem_read_data(b_mrdata),
    .grant_id(b_gid), .busy(b_busy)
  );

  // Memory models: read data LA / LB cycles after the address is presented.
  always @(posedge clk) mem_read_data <= rom[mem_address[7:2]];
  always @(posedge clk) begin
    b_p1     <= rom[b_maddr[7:2]];
    b_p2     <= b_p1;
    b_mrdata <= b_p2;
  end

  typedef struct {int due; int id; logic [31:0] data;} rsp_t;
  rsp_t rspq[$];

  int          cyc, n_chk, n_pass;
  bit          m_busy;
  int          m_gid, m_last, m_cnt;
  logic        e_mrd, e_mwr;
  logic [31:0] e_addr, e_wd, e_rspd;
  logic [3:0]  e_ws;
  logic [N-1:0] e_rspv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
    e_mrd = 0; e_mwr = 0; e_wd = 0; e_ws = 0; e_addr = 0; e_rspv = '0; e_rspd = 0;
    rspq.delete();
  endtask

  // Next-cycle expectations from the current inputs.
  task automatic model_advance();
    rsp_t r;
    int   g;
    if (rst) begin
      model_reset();
      return;
    end
    e_mrd = 0; e_mwr = 0; e_wd = 0; e_ws = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        g = (m_last + k) % N;
        if (req_valid[g]) begin
          m_gid = g; m_last = g; m_busy = 1; m_cnt = 0;
          break;
        end
      end
    end else if (req_valid[m_gid]) begin
      g = m_gid;
      e_addr = req_addr[g*AW +: AW];
      if (req_write[g]) begin
        e_mwr = 1; e_wd = req_wdata[g*DW +: DW]; e_ws = req_wstrb[g*SW +: SW];
      end else begin
        e_mrd = 1;
        r.due = cyc + 2 + LA; r.id = g; r.data = rom[e_addr[7:2]];
        rspq.push_back(r);
      end
      if (req_last[g] || m_cnt == MB - 1) m_busy = 0;
      m_cnt++;
    end
    e_rspv = '0;
    if (rspq.size() > 0 && rspq[0].due == cyc + 1) begin
      e_rspv[rspq[0].id] = 1'b1;
      e_rspd = rspq[0].data;
      void'(rspq.pop_front());
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] er;
    er = '0;
    if (m_busy) er[m_gid] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("mem_read", mem_read, e_mrd);
    chk("mem_write", mem_write, e_mwr);
    if (e_mrd || e_mwr) chk("mem_address", mem_address, e_addr);
    chk("mem_write_data", mem_write_data, e_wd);
    chk("mem_write_strb", mem_write_strb, e_ws);
    chk("rsp_valid", rsp_valid, e_rspv);
    if (e_rspv != 0) chk("rsp_rdata", rsp_rdata, e_rspd);
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid[i] = v; req_write[i] = w; req_last[i] = l;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_last = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int bc [N];
  int order [$];
  int nw, n0, w, k;
  bit rel, pb;
  logic [N-1:0] acc;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[16] = 32'hDEAD_BEEF;
    cyc = 0; n_chk = 0; n_pass = 0;
    model_reset();
    clear_inputs();
    b_valid = '0; b_write = '0; b_last = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    @(negedge clk);
    step();

    // Reset state and first arbitration
    do_reset();
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_mem_read", mem_read, 0);
    chk("t1_mem_write", mem_write, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ready_idle", req_ready, 0);
    chk("t1_grant_id", grant_id, 0);
    req_valid = 2'b11; req_write = 2'b11; req_last = 2'b11;
    step();
    chk("t1_ready_first", req_ready, 2'b01);

    // Round-robin with 2-beat write bursts
    do_reset();
    order.delete(); nw = 0;
    for (int i = 0; i < N; i++) begin
      bc[i] = 0;
      set_req(i, 1, 1, 0, 32'(i * 64), 32'hA000_0000 | 32'(i << 8), 4'hF - 4'(i));
    end
    for (int c = 0; c < 40 && (bc[0] + bc[1]) < 8; c++) begin
      acc = req_valid & req_ready;
      pb = busy;
      step();
      if (busy && !pb) order.push_back(int'(grant_id));
      if (mem_write) nw++;
      for (int i = 0; i < N; i++) if (acc[i]) begin
        bc[i]++;
        set_req(i, bc[i] < 4, 1, bc[i] % 2 == 1, 32'(i * 64 + bc[i] * 4),
                32'hA000_0000 | 32'(i << 8) | 32'(bc[i]), 4'(bc[i] + i));
      end
    end
    chk("t2_grants", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", order[i], i % 2);
    chk("t2_writes", nw, 8);

    // Read routing to requester 1
    do_reset();
    set_req(1, 1, 0, 1, 32'h40, 32'h0, 4'h0);
    w = 0;
    while (!req_ready[1] && w < 5) begin step(); w++; end
    chk("t3_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    k = 1;
    while (!rsp_valid[1] && k < 12) begin step(); k++; end
    chk("t3_latency", k, 3);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Forced release after MAX_BURST beats
    do_reset();
    set_req(0, 1, 1, 0, 32'h0, 32'h1111_0000, 4'h3);
    set_req(1, 1, 1, 1, 32'h80, 32'h2222_0000, 4'hC);
    n0 = 0; rel = 0;
    for (int c = 0; c < 30 && !rel; c++) begin
      acc = req_valid & req_ready;
      pb = busy;
      step();
      if (acc[0]) begin
        n0++;
        set_req(0, 1, 1, 0, 32'(n0 * 4), 32'h1111_0000 | 32'(n0), 4'h3);
      end
      if (pb && !busy) rel = 1;
    end
    chk("t4_beats", n0, MB);
    w = 0;
    while (!busy && w < 5) begin step(); w++; end
    chk("t4_next_grant", grant_id, 1);

    // Stall inside a grant
    do_reset();
    bc[0] = 0;
    set_req(0, 1, 1, 0, 32'h0, 32'h3300_0000, 4'h5);
    set_req(1, 1, 1, 1, 32'h90, 32'h4400_0000, 4'hA);
    for (int c = 0; c < 20 && bc[0] < 2; c++) begin
      acc = req_valid & req_ready;
      step();
      if (acc[0]) bc[0]++;
    end
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_gap_busy", busy, 1);
      chk("t5_gap_grant", grant_id, 0);
      chk("t5_gap_wr", mem_write, 0);
      chk("t5_gap_rd", mem_read, 0);
    end
    set_req(0, 1, 1, 0, 32'h8, 32'h3300_0002, 4'h5);
    for (int c = 0; c < 20 && bc[0] < 4; c++) begin
      acc = req_valid & req_ready;
      step();
      if (acc[0]) begin
        bc[0]++;
        set_req(0, bc[0] < 4, 1, bc[0] == 3, 32'(bc[0] * 4), 32'h3300_0000 | 32'(bc[0]), 4'h5);
      end
    end
    chk("t5_beats", bc[0], 4);
    w = 0;
    while (!busy && w < 5) begin step(); w++; end
    chk("t5_next_grant", grant_id, 1);

    // Reset while a read is in flight
    do_reset();
    set_req(0, 1, 0, 1, 32'h44, 32'h0, 4'h0);
    step();
    step();
    req_valid = '0;
    chk("t6_mem_read", mem_read, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t6_no_rsp", rsp_valid, 0);
      chk("t6_idle", busy, 0);
    end

    // Random traffic
    do_reset();
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i])
          set_req(i, ($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 4) == 0,
                  32'(($urandom % 64) << 2), $urandom, 4'($urandom));
      end
      rst = ($urandom % 400) == 0;
      acc = req_valid & req_ready;
      step();
    end
    rst = 1'b0;
    clear_inputs();
    step();

    // Read latency 3 on the second instance
    b_valid = 2'b10; b_write = 2'b00; b_last = 2'b10; b_addr = {32'h40, 32'h0};
    w = 0;
    while (!b_ready[1] && w < 5) begin step(); w++; end
    chk("t3b_grant", b_ready, 2'b10);
    step();
    b_valid = '0;
    k = 1;
    while (!b_rsp_valid[1] && k < 12) begin step(); k++; end
    chk("t3b_latency", k, 5);
    chk("t3b_rsp_valid", b_rsp_valid, 2'b10);
    chk("t3b_rdata", b_rsp_rdata, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
